raw_fifo_frame_arbiter: RTL and testbench
=========================================

// Module: raw_fifo_frame_arbiter
// PURPOSE
//  Frame-granular write arbiter that shares one raw_9b_fifo (8192 x 9, bit8 = end-of-frame marker) between two byte-stream
//  sources (e.g. MAC RX and loopback/test generator). Grants round-robin at frame boundaries, never interleaves frames,
//  only starts a frame when the FIFO has room for a max-size frame, and keeps a count of complete frames for the read side.
// PARAMETERS
//  CNT_W        4     width of frames_pending counter (saturating)
//  STALL_LIMIT  1024  source-idle cycles mid-frame before forced abort (used only with RAW_ARB_STALL_ABORT_EN)
//  ABORT_BYTE   8'h00 data byte written as forced terminator on abort
// PORTS
//  clk             in   1      system clock
//  rst             in   1      synchronous reset, active-high
//  s0_data         in   8      source 0 byte
//  s0_valid        in   1      source 0 byte valid
//  s0_last         in   1      source 0 byte is last of frame
//  s0_ready        out  1      source 0 byte accepted when valid&ready
//  s1_data/s1_valid/s1_last/s1_ready   same as source 0, for source 1
//  fifo_di         out  9      {last, data} to FIFO di
//  fifo_we         out  1      FIFO write enable
//  fifo_full       in   1      FIFO full_flag
//  fifo_afull      in   1      FIFO afull_flag (threshold leaves >= 1518 bytes headroom)
//  frame_pop       in   1      1-cycle pulse: read side consumed a byte with bit8=1
//  frames_pending  out  CNT_W  complete frames currently held in FIFO
//  grant           out  2      one-hot granted source, 2'b00 when idle
//  abort           out  1      1-cycle pulse when a frame is force-terminated
// BEHAVIOUR
//  - Reset: state=IDLE, grant=0, s*_ready=0, fifo_we=0, fifo_di=0, frames_pending=0, abort=0, rr pointer prefers s0.
//  - States: IDLE -> XFER -> IDLE (ABORT added with macro). grant is registered; ready/we/di are combinational from grant.
//  - IDLE: if !fifo_afull and any s*_valid, grant next cycle: both valid -> source not served last; one valid -> that source.
//    fifo_afull=1 blocks new grants only. Minimum one IDLE cycle between frames (arbitration bubble).
//  - XFER: sX_ready = grant[X] & !fifo_full; other source ready=0. fifo_we = valid&ready of granted source (same cycle),
//    fifo_di = {last, data}. fifo_full mid-frame stalls without loss; afull mid-frame is ignored.
//  - Accepted byte with last=1: frame complete -> frames_pending+1, rr pointer = served source, grant clears, state=IDLE.
//  - frames_pending: +1 on completed write, -1 on frame_pop, both same cycle -> unchanged; saturates at 2^CNT_W-1;
//    frame_pop at 0 ignored.
//  - Single-byte frame (valid&last on first XFER cycle) is legal: one write, count+1.
//  - Reset mid-frame: immediate return to reset values; partial frame in FIFO is the owner's problem (FIFO shares rst).
// CONFIGURATION
//  RAW_ARB_STALL_ABORT_EN defined:
//   - XFER counts consecutive cycles with granted sX_valid=0; count clears on any accepted byte.
//   - At STALL_LIMIT: state ABORT; writes {1'b1, ABORT_BYTE} when !fifo_full, pulses abort, frames_pending+1, rr update,
//     -> IDLE. Aborted source's drop flag set: its ready=1 and bytes discarded (no write) up to and incl. its next last;
//     the flag blocks granting that source until cleared; the other source arbitrates normally meanwhile.
//  Not defined: no stall counter, no ABORT state, no drop flags; abort tied 0; a stalled source holds the grant forever.
// TESTING
//  1. s0 sends 64-byte frame, s1 idle -> 64 writes, last has di[8]=1, frames_pending 0->1, grant 2'b01 then 2'b00.
//  2. s0,s1 both valid continuously with 3-byte frames -> grants alternate 01,10,01,...; no interleaved bytes in FIFO.
//  3. fifo_afull=1 in IDLE with s1 valid -> no grant, ready=0; afull drops -> grant 2'b10 next cycle.
//  4. fifo_full asserted 5 cycles mid-frame -> ready=0, no we for 5 cycles; frame resumes, all bytes in order.
//  5. frame completes same cycle as frame_pop with pending=2 -> stays 2; frame_pop at 0 -> stays 0.
//  6. (macro on, STALL_LIMIT=16) s0 stops valid after 10 bytes -> after 16 idle cycles write {1,8'h00}, abort pulse,
//     pending+1; s0 resumes 5 bytes with last -> discarded, no writes; s1 frame granted meanwhile.

Source files
------------

// File: rtl/raw_fifo_frame_arbiter.sv
// Frame-granular round-robin write arbiter sharing one 9-bit raw FIFO between two byte sources.
// Optional stall recovery (forced frame abort + drop of the stalled source's remainder): `define RAW_ARB_STALL_ABORT_EN.
module raw_fifo_frame_arbiter #(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned STALL_LIMIT = 1024,
  parameter logic [7:0]  ABORT_BYTE  = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s0_data,
  input  logic             s0_valid,
  input  logic             s0_last,
  output logic             s0_ready,
  input  logic [7:0]       s1_data,
  input  logic             s1_valid,
  input  logic             s1_last,
  output logic             s1_ready,
  output logic [8:0]       fifo_di,
  output logic             fifo_we,
  input  logic             fifo_full,
  input  logic             fifo_afull,
  input  logic             frame_pop,
  output logic [CNT_W-1:0] frames_pending,
  output logic [1:0]       grant,
  output logic             abort
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;

  logic [1:0] state;
  logic       rr_last;  // source served most recently; reset to 1 so s0 wins the first tie
  logic [1:0] drop;
  logic [1:0] elig;
  logic       sel;
  logic       g_valid;
  logic       g_last;
  logic [7:0] g_data;
  logic       accept;
  logic       done;
  logic       pend_dec;

`ifdef RAW_ARB_STALL_ABORT_EN
  localparam logic [1:0]  ST_ABORT = 2'd2;
  localparam int unsigned SC_W     = $clog2(STALL_LIMIT + 1);
  logic [SC_W-1:0] stall_cnt;
`endif

  always_comb begin
    sel      = grant[1];
    g_valid  = sel ? s1_valid : s0_valid;
    g_last   = sel ? s1_last  : s0_last;
    g_data   = sel ? s1_data  : s0_data;
    elig     = {s1_valid & ~drop[1], s0_valid & ~drop[0]};
    s0_ready = drop[0] | (state == ST_XFER && grant[0] && !fifo_full);
    s1_ready = drop[1] | (state == ST_XFER && grant[1] && !fifo_full);
    accept   = (state == ST_XFER) && (grant != 2'b00) && g_valid && !fifo_full;
    fifo_we  = accept;
    fifo_di  = accept ? {g_last, g_data} : '0;
    abort    = 1'b0;
`ifdef RAW_ARB_STALL_ABORT_EN
    if (state == ST_ABORT && !fifo_full) begin
      fifo_we = 1'b1;
      fifo_di = {1'b1, ABORT_BYTE};
      abort   = 1'b1;
    end
`endif
    done     = (accept && g_last) || abort;
    pend_dec = frame_pop && (frames_pending != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant   <= '0;
      rr_last <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_afull && elig != 2'b00) begin
            state <= ST_XFER;
            grant <= (elig == 2'b11) ? (rr_last ? 2'b01 : 2'b10) : elig;
          end
        end
        ST_XFER: begin
          if (accept && g_last) begin
            state   <= ST_IDLE;
            grant   <= '0;
            rr_last <= sel;
          end
`ifdef RAW_ARB_STALL_ABORT_EN
          else if (!g_valid && stall_cnt == SC_W'(STALL_LIMIT - 1)) begin
            state <= ST_ABORT;
          end
`endif
        end
`ifdef RAW_ARB_STALL_ABORT_EN
        ST_ABORT: begin
          if (abort) begin
            state   <= ST_IDLE;
            grant   <= '0;
            rr_last <= sel;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Simultaneous completion and pop cancel; pop at zero is ignored, increment saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_pending <= '0;
    end else if (done && !pend_dec) begin
      if (frames_pending != '1) frames_pending <= frames_pending + CNT_W'(1);
    end else if (!done && pend_dec) begin
      frames_pending <= frames_pending - CNT_W'(1);
    end
  end

`ifdef RAW_ARB_STALL_ABORT_EN
  // Stall counter only advances on idle cycles of the granted source; any accepted byte restarts it.
  always_ff @(posedge clk) begin
    if (rst || state != ST_XFER || accept) stall_cnt <= '0;
    else if (!g_valid) stall_cnt <= stall_cnt + SC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop <= '0;
    end else begin
      if (drop[0] && s0_valid && s0_last) drop[0] <= 1'b0;
      if (drop[1] && s1_valid && s1_last) drop[1] <= 1'b0;
      if (abort) drop[sel] <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign drop       = '0;
  assign unused_cfg = ^{STALL_LIMIT, ABORT_BYTE};
`endif

endmodule

// File: tb/tb_raw_fifo_frame_arbiter.sv
// Self-checking bench for raw_fifo_frame_arbiter: arbitration vector table, scoreboarded source streams,
// and hand sequences for afull/full stalls, pending-count corners and (with RAW_ARB_STALL_ABORT_EN) stall abort.
module tb_raw_fifo_frame_arbiter;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [7:0]       s0_data, s1_data;
  logic             s0_valid, s0_last, s0_ready;
  logic             s1_valid, s1_last, s1_ready;
  logic [8:0]       fifo_di;
  logic             fifo_we, fifo_full, fifo_afull, frame_pop;
  logic [CNT_W-1:0] frames_pending;
  logic [1:0]       grant;
  logic             abort;

  raw_fifo_frame_arbiter #(
    .CNT_W      (CNT_W),
`ifdef RAW_ARB_STALL_ABORT_EN
    .STALL_LIMIT(16),
`else
    .STALL_LIMIT(1024),
`endif
    .ABORT_BYTE (8'h00)
  ) dut (
    .clk(clk), .rst(rst),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .fifo_di(fifo_di), .fifo_we(fifo_we), .fifo_full(fifo_full), .fifo_afull(fifo_afull),
    .frame_pop(frame_pop), .frames_pending(frames_pending), .grant(grant), .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic        v1;
    logic        afull;
    logic [1:0]  exp_grant;
    int unsigned exp_pend;
  } arb_vec_t;

  arb_vec_t    vecs [10];
  logic [8:0]  src_q0[$], src_q1[$], exp_q[$];
  logic [1:0]  grant_log[$];
  logic [1:0]  prev_grant = 2'b00;
  bit          drv_en = 1'b0;
  bit          acc0 = 1'b0, acc1 = 1'b0;
  bit          seen;
  int unsigned n_checks = 0, n_fail = 0, n_writes = 0, n_aborts = 0;
  int unsigned w0, idle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Negedge monitor: write scoreboard, acceptance sampling for the source drivers, grant history.
  always @(negedge clk) begin
    acc0 = s0_valid & s0_ready;
    acc1 = s1_valid & s1_ready;
    if (fifo_we) begin
      n_writes++;
      if (exp_q.size() == 0) check("unexpected_fifo_write", 32'(fifo_di), 32'h1ff);
      else check("fifo_write_di", 32'(fifo_di), 32'(exp_q.pop_front()));
    end
    if (grant != prev_grant) begin
      if (grant != 2'b00) grant_log.push_back(grant);
      prev_grant = grant;
    end
    if (abort) n_aborts++;
  end

  task automatic drive_sources();
    forever begin
      @(posedge clk);
      if (drv_en) begin
        if (acc0 && src_q0.size() > 0) void'(src_q0.pop_front());
        if (acc1 && src_q1.size() > 0) void'(src_q1.pop_front());
        #1;
        if (src_q0.size() > 0) begin s0_valid = 1'b1; {s0_last, s0_data} = src_q0[0]; end
        else begin s0_valid = 1'b0; s0_last = 1'b0; s0_data = '0; end
        if (src_q1.size() > 0) begin s1_valid = 1'b1; {s1_last, s1_data} = src_q1[0]; end
        else begin s1_valid = 1'b0; s1_last = 1'b0; s1_data = '0; end
      end
    end
  endtask

  task automatic send_frame(input int unsigned src, input logic [7:0] base, input int unsigned len,
                            input bit with_last, input bit expect_write);
    for (int unsigned i = 0; i < len; i++) begin
      logic [8:0] w;
      w = {with_last && (i == len - 1), base + 8'(i)};
      if (src == 0) src_q0.push_back(w); else src_q1.push_back(w);
      if (expect_write) exp_q.push_back(w);
    end
  endtask

  task automatic wait_grant(input logic [1:0] g, input int unsigned budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #2;
      if (grant == g) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int unsigned budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #2;
      if (src_q0.size() == 0 && src_q1.size() == 0 && grant == 2'b00 && !s0_valid && !s1_valid) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic pop_frames(input int unsigned n);
    frame_pop = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    frame_pop = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // {s0_valid, s1_valid, afull, expected grant, expected frames_pending after the slot}
    vecs[0] = '{1'b1, 1'b1, 1'b0, 2'b01, 32'd1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 2'b10, 32'd2};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 2'b01, 32'd3};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 2'b10, 32'd4};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 2'b10, 32'd5};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 2'b01, 32'd6};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 2'b00, 32'd6};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'd6};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 2'b01, 32'd7};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 2'b00, 32'd7};

    rst = 1'b1; s0_valid = 1'b1; s0_last = 1'b0; s0_data = 8'h55;
    s1_valid = 1'b0; s1_last = 1'b0; s1_data = '0;
    fifo_full = 1'b0; fifo_afull = 1'b0; frame_pop = 1'b0;
    fork drive_sources(); join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_s0_ready", 32'(s0_ready), 32'd0);
    check("rst_s1_ready", 32'(s1_ready), 32'd0);
    check("rst_fifo_we", 32'(fifo_we), 32'd0);
    check("rst_fifo_di", 32'(fifo_di), 32'd0);
    check("rst_pending", 32'(frames_pending), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; s0_valid = 1'b0;
    @(posedge clk); #2;

    // Arbitration table: single-byte frames offered for one IDLE cycle each.
    for (int unsigned i = 0; i < 10; i++) begin
      s0_valid = vecs[i].v0; s1_valid = vecs[i].v1; s0_last = 1'b1; s1_last = 1'b1;
      s0_data = 8'h10 + 8'(i); s1_data = 8'h80 + 8'(i); fifo_afull = vecs[i].afull;
      if (vecs[i].exp_grant == 2'b01) exp_q.push_back({1'b1, s0_data});
      if (vecs[i].exp_grant == 2'b10) exp_q.push_back({1'b1, s1_data});
      @(posedge clk); #2;
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      if (!vecs[i].exp_grant[0]) s0_valid = 1'b0;
      if (!vecs[i].exp_grant[1]) s1_valid = 1'b0;
      @(posedge clk); #2;
      check($sformatf("vec%0d_pending", i), 32'(frames_pending), vecs[i].exp_pend);
      s0_valid = 1'b0; s1_valid = 1'b0; s0_last = 1'b0; s1_last = 1'b0; fifo_afull = 1'b0;
      @(posedge clk); #2;
    end

    pop_frames(7);
    check("pop_to_zero", 32'(frames_pending), 32'd0);
    pop_frames(1);
    check("pop_at_zero", 32'(frames_pending), 32'd0);
    drv_en = 1'b1;

    // 64-byte frame from s0 alone.
    w0 = n_writes;
    send_frame(0, 8'h00, 64, 1'b1, 1'b1);
    wait_grant(2'b01, 10, "t1_grant_s0");
    wait_idle(200, "t1_idle");
    check("t1_writes", n_writes - w0, 32'd64);
    check("t1_pending", 32'(frames_pending), 32'd1);
    check("t1_grant_cleared", 32'(grant), 32'd0);

    // Both sources continuously valid with 3-byte frames; s0 was served last so s1 leads.
    grant_log.delete();
    for (int unsigned f = 0; f < 3; f++) begin
      send_frame(1, 8'hB0 + 8'(4 * f), 3, 1'b1, 1'b1);
      send_frame(0, 8'hA0 + 8'(4 * f), 3, 1'b1, 1'b1);
    end
    wait_idle(200, "t2_idle");
    check("t2_grant_count", 32'(grant_log.size()), 32'd6);
    for (int unsigned i = 0; i < 6 && i < grant_log.size(); i++)
      check($sformatf("t2_grant%0d", i), 32'(grant_log[i]), (i % 2 == 0) ? 32'd2 : 32'd1);
    check("t2_pending", 32'(frames_pending), 32'd7);

    // afull blocks a new grant in IDLE.
    fifo_afull = 1'b1;
    send_frame(1, 8'hE0, 2, 1'b1, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("t3_afull_grant", 32'(grant), 32'd0);
      check("t3_afull_s1_ready", 32'(s1_ready), 32'd0);
    end
    @(posedge clk); #2;
    fifo_afull = 1'b0;
    @(posedge clk); #2;
    check("t3_release_grant", 32'(grant), 32'd2);
    wait_idle(50, "t3_idle");
    check("t3_pending", 32'(frames_pending), 32'd8);

    // fifo_full for 5 cycles mid-frame.
    w0 = n_writes;
    send_frame(0, 8'h40, 8, 1'b1, 1'b1);
    wait_grant(2'b01, 10, "t4_grant_s0");
    repeat (3) @(posedge clk);
    #2;
    fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4_full_s0_ready", 32'(s0_ready), 32'd0);
      check("t4_full_we", 32'(fifo_we), 32'd0);
    end
    @(posedge clk); #2;
    fifo_full = 1'b0;
    wait_idle(50, "t4_idle");
    check("t4_writes", n_writes - w0, 32'd8);
    check("t4_pending", 32'(frames_pending), 32'd9);

    // Completion and pop in the same cycle; single-byte frame.
    pop_frames(7);
    check("t5_pending_two", 32'(frames_pending), 32'd2);
    send_frame(1, 8'h5A, 1, 1'b1, 1'b1);
    wait_grant(2'b10, 10, "t5_grant_s1");
    frame_pop = 1'b1;
    @(posedge clk); #2;
    frame_pop = 1'b0;
    check("t5_pending_cancel", 32'(frames_pending), 32'd2);
    check("t5_grant_cleared", 32'(grant), 32'd0);

    // Saturation at 2^CNT_W-1.
    for (int unsigned i = 0; i < 14; i++) send_frame(0, 8'hC0 + 8'(i), 1, 1'b1, 1'b1);
    wait_idle(200, "t5_sat_idle");
    check("t5_saturated", 32'(frames_pending), 32'd15);
    pop_frames(1);
    check("t5_pop_from_sat", 32'(frames_pending), 32'd14);
    pop_frames(10);
    check("t5_pending_four", 32'(frames_pending), 32'd4);

`ifdef RAW_ARB_STALL_ABORT_EN
    // s0 stalls after 10 bytes -> forced terminator, then its 5-byte remainder is discarded.
    send_frame(0, 8'h60, 10, 1'b0, 1'b1);
    exp_q.push_back({1'b1, 8'h00});
    wait_grant(2'b01, 10, "t6_grant_s0");
    idle = 0; seen = 1'b0;
    for (int unsigned i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (abort) seen = 1'b1;
      else if (grant == 2'b01 && !s0_valid) idle++;
    end
    check("t6_abort_seen", 32'(seen), 32'd1);
    check("t6_stall_cycles", idle, 32'd16);
    send_frame(0, 8'h70, 5, 1'b1, 1'b0);
    send_frame(1, 8'h90, 3, 1'b1, 1'b1);
    wait_grant(2'b10, 10, "t6_grant_s1_during_drop");
    check("t6_s0_still_dropping", 32'(src_q0.size() > 0), 32'd1);
    wait_idle(100, "t6_idle");
    check("t6_abort_pulses", n_aborts, 32'd1);
    check("t6_pending", 32'(frames_pending), 32'd6);
`else
    check("abort_tied_low", n_aborts, 32'd0);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
